// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl -- MEM-stage data-memory access unit for external async SRAM.
//
// Sits between the EX/MEM register and the mem stage. Loads and stores are
// turned into multi-cycle SRAM strobe sequences while stallReq_o holds the
// upstream pipeline. Non-memory instructions pass straight through.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   memRead_i       load in EX/MEM
//   memWrite_i      store in EX/MEM (wins over memRead_i when both are set)
//   memAddr_i       data address, zero-extended onto ram_addr_o
//   memWData_i      store data
//   aluResult_i     write-back data for non-load instructions
//   wReg_i          instruction writes a register
//   wRegAddr_i      destination register
//   stallReq_o      hold IF..EX/MEM while an access is requested or in flight
//   wData_o         write-back data towards mem.wData_i
//   wReg_o          write-back enable towards mem.wReg_i
//   wRegAddr_o      destination towards mem.wRegAddr_i
//   ram_addr_o      SRAM address (registered)
//   ram_wdata_o     SRAM write data (registered)
//   ram_rdata_i     SRAM read data
//   ram_ce_n_o      chip enable, active-low (registered)
//   ram_oe_n_o      output enable, active-low (registered)
//   ram_we_n_o      write enable, active-low (registered)

module mem_sram_ctrl #(
   parameter int DATA_W      = 16,
   parameter int REG_ADDR_W  = 4,
   parameter int ADDR_W      = 18,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  memRead_i,
   input  logic                  memWrite_i,
   input  logic [DATA_W-1:0]     memAddr_i,
   input  logic [DATA_W-1:0]     memWData_i,
   input  logic [DATA_W-1:0]     aluResult_i,
   input  logic                  wReg_i,
   input  logic [REG_ADDR_W-1:0] wRegAddr_i,
   output logic                  stallReq_o,
   output logic [DATA_W-1:0]     wData_o,
   output logic                  wReg_o,
   output logic [REG_ADDR_W-1:0] wRegAddr_o,
   output logic [ADDR_W-1:0]     ram_addr_o,
   output logic [DATA_W-1:0]     ram_wdata_o,
   input  logic [DATA_W-1:0]     ram_rdata_i,
   output logic                  ram_ce_n_o,
   output logic                  ram_oe_n_o,
   output logic                  ram_we_n_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [3:0] COUNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t              state, state_nx;
   logic [3:0]          count;
   logic [DATA_W-1:0]   rdata_q;
   logic                was_read_q;   // selects rdata_q vs aluResult_i in DONE

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next state and combinational pipeline-facing outputs
   always_comb begin
      state_nx   = state;
      stallReq_o = 1'b0;
      wData_o    = '0;
      wReg_o     = 1'b0;
      wRegAddr_o = '0;
      case (state)
         IDLE: begin
            if (memWrite_i) begin
               state_nx   = WRITE;
               stallReq_o = 1'b1;
            end else if (memRead_i) begin
               state_nx   = READ;
               stallReq_o = 1'b1;
            end else begin
               wData_o    = aluResult_i;
               wReg_o     = wReg_i;
               wRegAddr_o = wRegAddr_i;
            end
         end
         READ, WRITE: begin
            stallReq_o = 1'b1;
            if (count == 4'd0) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            // Unconditional return: the still-held request must not restart.
            state_nx   = IDLE;
            wData_o    = was_read_q ? rdata_q : aluResult_i;
            wReg_o     = wReg_i;
            wRegAddr_o = wRegAddr_i;
         end
         default: state_nx = IDLE;
      endcase
   end

   // SRAM-side datapath: address/data latch, wait counter, registered strobes.
   // Strobes are loaded on entry to READ/WRITE and released on the final
   // strobe cycle, so they are low for exactly WAIT_CYCLES cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count       <= '0;
         rdata_q     <= '0;
         was_read_q  <= 1'b0;
         ram_addr_o  <= '0;
         ram_wdata_o <= '0;
         ram_ce_n_o  <= 1'b1;
         ram_oe_n_o  <= 1'b1;
         ram_we_n_o  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (memWrite_i || memRead_i) begin
                  ram_addr_o  <= ADDR_W'(memAddr_i);
                  ram_wdata_o <= memWData_i;
                  count       <= COUNT_INIT;
                  was_read_q  <= ~memWrite_i;
                  ram_ce_n_o  <= 1'b0;
                  ram_oe_n_o  <= memWrite_i;
                  ram_we_n_o  <= ~memWrite_i;
               end
            end
            READ, WRITE: begin
               if (count == 4'd0) begin
                  if (state == READ) begin
                     rdata_q <= ram_rdata_i;
                  end
                  ram_ce_n_o <= 1'b1;
                  ram_oe_n_o <= 1'b1;
                  ram_we_n_o <= 1'b1;
               end else begin
                  count <= count - 4'd1;
               end
            end
            default: ;   // DONE: address and write data held for hold time
         endcase
      end
   end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl -- directed bench for mem_sram_ctrl with a small SRAM model.

module tb_mem_sram_ctrl;

   localparam int DW = 16;
   localparam int RW = 4;
   localparam int AW = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic          memRead_i, memWrite_i;
   logic [DW-1:0] memAddr_i, memWData_i, aluResult_i;
   logic          wReg_i;
   logic [RW-1:0] wRegAddr_i;
   logic          stallReq_o;
   logic [DW-1:0] wData_o;
   logic          wReg_o;
   logic [RW-1:0] wRegAddr_o;
   logic [AW-1:0] ram_addr_o;
   logic [DW-1:0] ram_wdata_o;
   logic [DW-1:0] ram_rdata_i;
   logic          ram_ce_n_o, ram_oe_n_o, ram_we_n_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_sram_ctrl #(
      .DATA_W      (DW),
      .REG_ADDR_W  (RW),
      .ADDR_W      (AW),
      .WAIT_CYCLES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .memRead_i   (memRead_i),
      .memWrite_i  (memWrite_i),
      .memAddr_i   (memAddr_i),
      .memWData_i  (memWData_i),
      .aluResult_i (aluResult_i),
      .wReg_i      (wReg_i),
      .wRegAddr_i  (wRegAddr_i),
      .stallReq_o  (stallReq_o),
      .wData_o     (wData_o),
      .wReg_o      (wReg_o),
      .wRegAddr_o  (wRegAddr_o),
      .ram_addr_o  (ram_addr_o),
      .ram_wdata_o (ram_wdata_o),
      .ram_rdata_i (ram_rdata_i),
      .ram_ce_n_o  (ram_ce_n_o),
      .ram_oe_n_o  (ram_oe_n_o),
      .ram_we_n_o  (ram_we_n_o)
   );

   // Async SRAM model: combinational read, write on clock while ce/we low.
   logic [DW-1:0] sram [0:1023];
   logic          pre_en = 1'b0;
   logic [9:0]    pre_a  = '0;
   logic [DW-1:0] pre_d  = '0;

   assign ram_rdata_i = (!ram_ce_n_o && !ram_oe_n_o) ? sram[ram_addr_o[9:0]] : '0;

   always @(posedge clk) begin
      if (pre_en)
         sram[pre_a] <= pre_d;
      else if (!ram_ce_n_o && !ram_we_n_o)
         sram[ram_addr_o[9:0]] <= ram_wdata_o;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic preload(input logic [9:0] a, input logic [DW-1:0] d);
      pre_en = 1'b1;
      pre_a  = a;
      pre_d  = d;
      @(posedge clk);
      #1 pre_en = 1'b0;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] alu,
                        input logic wreg, input logic [RW-1:0] wra);
      memRead_i   = rd;
      memWrite_i  = wr;
      memAddr_i   = addr;
      memWData_i  = wd;
      aluResult_i = alu;
      wReg_i      = wreg;
      wRegAddr_i  = wra;
   endtask

   // Called just after a rising edge with a request already driven. Returns at
   // the negedge of the DONE cycle (first cycle with stall low).
   task automatic run_access(input string tag, output int st, output int ce,
                             output int oe, output int we,
                             output logic [AW-1:0] a, output logic [DW-1:0] wd);
      st = 0; ce = 0; oe = 0; we = 0; a = '0; wd = '0;
      @(negedge clk);
      check({tag, "_bubble"}, {14'd0, stallReq_o, wReg_o, wData_o}, 32'h0002_0000);
      if (stallReq_o) st = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!stallReq_o) break;
         st++;
         if (!ram_ce_n_o) begin
            ce++;
            a  = ram_addr_o;
            wd = ram_wdata_o;
         end
         if (!ram_oe_n_o) oe++;
         if (!ram_we_n_o) we++;
      end
      if (stallReq_o) check({tag, "_timeout"}, 32'd1, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, ce, oe, we, st2;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;

      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      preload(10'h040, 16'hBEEF);

      // Reset state
      @(negedge clk);
      check("rst_stall",   {31'd0, stallReq_o}, 32'd0);
      check("rst_wreg",    {31'd0, wReg_o}, 32'd0);
      check("rst_wdata",   {16'd0, wData_o}, 32'd0);
      check("rst_strobes", {29'd0, ram_ce_n_o, ram_oe_n_o, ram_we_n_o}, 32'd7);
      check("rst_addr",    {14'd0, ram_addr_o}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // 1: ALU pass-through
      drive(1'b0, 1'b0, 16'h0040, '0, 16'h1234, 1'b1, 4'd3);
      @(negedge clk);
      check("alu_wdata", {16'd0, wData_o}, 32'h1234);
      check("alu_wreg",  {31'd0, wReg_o}, 32'd1);
      check("alu_waddr", {28'd0, wRegAddr_o}, 32'd3);
      check("alu_stall", {31'd0, stallReq_o}, 32'd0);
      @(negedge clk);
      check("alu_strobes", {29'd0, ram_ce_n_o, ram_oe_n_o, ram_we_n_o}, 32'd7);

      // 2: load 0x0040 -> BEEF
      @(posedge clk);
      #1 drive(1'b1, 1'b0, 16'h0040, '0, 16'h1111, 1'b1, 4'd5);
      run_access("ld", st, ce, oe, we, a, wd);
      check("ld_stall", st, 3);
      check("ld_ce",    ce, 2);
      check("ld_oe",    oe, 2);
      check("ld_we",    we, 0);
      check("ld_addr",  {14'd0, a}, 32'h0_0040);
      check("ld_wdata", {16'd0, wData_o}, 32'hBEEF);
      check("ld_wreg",  {31'd0, wReg_o}, 32'd1);
      check("ld_waddr", {28'd0, wRegAddr_o}, 32'd5);
      check("ld_done_strobes", {29'd0, ram_ce_n_o, ram_oe_n_o, ram_we_n_o}, 32'd7);
      @(posedge clk);
      #1 drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      @(negedge clk);
      check("ld_idle_stall", {31'd0, stallReq_o}, 32'd0);

      // 3: store A5A5 -> 0x0100
      @(posedge clk);
      #1 drive(1'b0, 1'b1, 16'h0100, 16'hA5A5, 16'h2222, 1'b0, 4'd0);
      run_access("st", st, ce, oe, we, a, wd);
      check("st_stall", st, 3);
      check("st_ce",    ce, 2);
      check("st_oe",    oe, 0);
      check("st_we",    we, 2);
      check("st_wd",    {16'd0, wd}, 32'hA5A5);
      check("st_addr_hold",  {14'd0, ram_addr_o}, 32'h0_0100);
      check("st_wdata_hold", {16'd0, ram_wdata_o}, 32'hA5A5);
      check("st_wb_data", {16'd0, wData_o}, 32'h2222);
      check("st_wb_wreg", {31'd0, wReg_o}, 32'd0);
      @(posedge clk);
      #1 drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      check("st_model", {16'd0, sram[10'h100]}, 32'hA5A5);

      // 4: store then load, back-to-back
      @(posedge clk);
      #1 drive(1'b0, 1'b1, 16'h0200, 16'hA5A5, 16'h0000, 1'b0, 4'd0);
      run_access("bb_st", st, ce, oe, we, a, wd);
      @(posedge clk);
      #1 drive(1'b1, 1'b0, 16'h0200, '0, 16'h4444, 1'b1, 4'd7);
      run_access("bb_ld", st2, ce, oe, we, a, wd);
      check("bb_stall_total", st + st2, 6);
      check("bb_ld_data",  {16'd0, wData_o}, 32'hA5A5);
      check("bb_ld_waddr", {28'd0, wRegAddr_o}, 32'd7);
      @(posedge clk);
      #1 drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);

      // 5: read and write together -> write wins
      @(posedge clk);
      #1 drive(1'b1, 1'b1, 16'h0300, 16'h1357, 16'h3333, 1'b1, 4'd2);
      run_access("rw", st, ce, oe, we, a, wd);
      check("rw_stall", st, 3);
      check("rw_oe",    oe, 0);
      check("rw_we",    we, 2);
      check("rw_wb",    {16'd0, wData_o}, 32'h3333);
      @(posedge clk);
      #1 drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      check("rw_model", {16'd0, sram[10'h300]}, 32'h1357);

      // 6: reset during the second READ cycle
      @(posedge clk);
      #1 drive(1'b1, 1'b0, 16'h0040, '0, 16'h0000, 1'b1, 4'd1);
      @(posedge clk);
      @(posedge clk);
      #1 check("mid_strobe_active", {30'd0, ram_ce_n_o, ram_oe_n_o}, 32'd0);
      #1 begin
         rst = 1'b1;
         drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      end
      #1;
      check("mid_rst_strobes", {29'd0, ram_ce_n_o, ram_oe_n_o, ram_we_n_o}, 32'd7);
      check("mid_rst_stall",   {31'd0, stallReq_o}, 32'd0);
      check("mid_rst_wdata",   {16'd0, wData_o}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_stall", {31'd0, stallReq_o}, 32'd0);

      // recovery: a fresh load completes normally
      @(posedge clk);
      #1 drive(1'b1, 1'b0, 16'h0040, '0, 16'h0000, 1'b1, 4'd9);
      run_access("rec", st, ce, oe, we, a, wd);
      check("rec_stall", st, 3);
      check("rec_data",  {16'd0, wData_o}, 32'hBEEF);
      @(posedge clk);
      #1 drive(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
      @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
